// File: rtl/multicycle_controller_if.sv
// Memory-side handshake between the multicycle controller and the shared
// instruction/data memory.
interface multicycle_controller_if;
    logic MemReq;
    logic MemWrite;
    logic AdrSrc;
    logic MemReady;

    modport master (output MemReq, output MemWrite, output AdrSrc, input MemReady);
    modport slave  (input MemReq, input MemWrite, input AdrSrc, output MemReady);
endinterface

// File: rtl/multicycle_controller.sv
// Main FSM for the multicycle RV32I datapath (lw, sw, R/I ALU, beq/bne, jal).
// Define RISCV_ILLEGAL_TRAP_EN to trap on unknown opcodes instead of retiring them as NOPs.
module multicycle_controller #(
    parameter int STALL_W = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    multicycle_controller_if.master mem,
    input  logic [6:0]              op,
    input  logic [2:0]              funct3,
    input  logic                    funct7b5,
    input  logic                    Zero,
    output logic                    IRWrite,
    output logic                    PCWrite,
    output logic                    RegWrite,
    output logic [1:0]              ResultSrc,
    output logic [1:0]              ALUSrcA,
    output logic [1:0]              ALUSrcB,
    output logic [1:0]              ImmSrc,
    output logic [2:0]              ALUControl,
    output logic                    InstrDone,
    output logic [STALL_W-1:0]      StallCount
`ifdef RISCV_ILLEGAL_TRAP_EN
    ,
    output logic                    Illegal
`endif
);
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
        EXECR, EXECI, ALUWB, BRANCH, JAL
`ifdef RISCV_ILLEGAL_TRAP_EN
        , TRAP
`endif
    } state_t;

    state_t     state;
    logic [1:0] aluop;

`ifndef RISCV_ILLEGAL_TRAP_EN
    logic known_op;
    assign known_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_R) ||
                      (op == OP_I) || (op == OP_BRANCH) || (op == OP_JAL);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= FETCH;
            StallCount <= '0;
`ifdef RISCV_ILLEGAL_TRAP_EN
            Illegal    <= 1'b0;
`endif
        end else begin
            if (mem.MemReq && !mem.MemReady && (StallCount != '1))
                StallCount <= StallCount + {{(STALL_W-1){1'b0}}, 1'b1};
            case (state)
                FETCH:    if (mem.MemReady) state <= DECODE;
                DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= MEMADR;
                        OP_R:              state <= EXECR;
                        OP_I:              state <= EXECI;
                        OP_BRANCH:         state <= BRANCH;
                        OP_JAL:            state <= JAL;
                        default: begin
`ifdef RISCV_ILLEGAL_TRAP_EN
                            state   <= TRAP;
                            Illegal <= 1'b1;
`else
                            state   <= FETCH;
`endif
                        end
                    endcase
                end
                // op[5] separates sw (0100011) from lw (0000011)
                MEMADR:   state <= op[5] ? MEMWRITE : MEMREAD;
                MEMREAD:  if (mem.MemReady) state <= MEMWB;
                MEMWB:    state <= FETCH;
                MEMWRITE: if (mem.MemReady) state <= FETCH;
                EXECR:    state <= ALUWB;
                EXECI:    state <= ALUWB;
                ALUWB:    state <= FETCH;
                BRANCH:   state <= FETCH;
                JAL:      state <= ALUWB;
`ifdef RISCV_ILLEGAL_TRAP_EN
                TRAP:     state <= TRAP;
`endif
                default:  state <= FETCH;
            endcase
        end
    end

    always_comb begin
        mem.MemReq   = 1'b0;
        mem.MemWrite = 1'b0;
        mem.AdrSrc   = 1'b0;
        IRWrite      = 1'b0;
        PCWrite      = 1'b0;
        RegWrite     = 1'b0;
        ResultSrc    = 2'b00;
        ALUSrcA      = 2'b00;
        ALUSrcB      = 2'b00;
        aluop        = 2'b00;
        InstrDone    = 1'b0;
        case (state)
            FETCH: begin
                mem.MemReq = 1'b1;
                ALUSrcB    = 2'b10;
                ResultSrc  = 2'b10;
                IRWrite    = mem.MemReady;
                PCWrite    = mem.MemReady;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
`ifndef RISCV_ILLEGAL_TRAP_EN
                InstrDone = !known_op;
`endif
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            MEMREAD: begin
                mem.MemReq = 1'b1;
                mem.AdrSrc = 1'b1;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            MEMWRITE: begin
                mem.MemReq   = 1'b1;
                mem.MemWrite = 1'b1;
                mem.AdrSrc   = 1'b1;
                InstrDone    = mem.MemReady;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                aluop   = 2'b10;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                aluop   = 2'b10;
            end
            ALUWB: begin
                RegWrite  = 1'b1;
                InstrDone = 1'b1;
            end
            BRANCH: begin
                ALUSrcA   = 2'b10;
                aluop     = 2'b01;
                InstrDone = 1'b1;
                PCWrite   = (funct3 == 3'b000) ? Zero :
                            (funct3 == 3'b001) ? !Zero : 1'b0;
            end
            JAL: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                PCWrite = 1'b1;
            end
            default: ;
        endcase
        // Reset must suppress every write immediately, not only after the next edge
        if (reset) begin
            mem.MemReq   = 1'b0;
            mem.MemWrite = 1'b0;
            IRWrite      = 1'b0;
            PCWrite      = 1'b0;
            RegWrite     = 1'b0;
            InstrDone    = 1'b0;
        end
    end

    always_comb begin
        ALUControl = 3'b000;
        case (aluop)
            2'b01: ALUControl = 3'b001;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUControl = (op[5] && funct7b5) ? 3'b001 : 3'b000;
                    3'b010:  ALUControl = 3'b101;
                    3'b110:  ALUControl = 3'b011;
                    3'b111:  ALUControl = 3'b010;
                    default: ALUControl = 3'b000;
                endcase
            end
            default: ALUControl = 3'b000;
        endcase
    end

    always_comb begin
        ImmSrc = 2'b00;
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end
endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: builds the expected per-cycle control word of each
// instruction from its class and wait states, and compares the DUT against it every cycle.
module tb_multicycle_controller;
    localparam int STALL_W = 8;

    typedef struct {
        logic       rst;
        logic       partial;
        logic       ready;
        logic       zero;
        logic       memreq;
        logic       memwrite;
        logic       adrsrc;
        logic       irwrite;
        logic       pcwrite;
        logic       regwrite;
        logic       instrdone;
        logic       illegal;
        logic [1:0] resultsrc;
        logic [1:0] srca;
        logic [1:0] srcb;
        logic [1:0] immsrc;
        logic [2:0] alucontrol;
    } cyc_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] op = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic funct7b5 = 1'b0;
    logic Zero = 1'b0;
    logic IRWrite, PCWrite, RegWrite, InstrDone;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [STALL_W-1:0] StallCount;
`ifdef RISCV_ILLEGAL_TRAP_EN
    logic Illegal;
`endif

    int total = 0;
    int bad = 0;
    int modelStall = 0;
    int runLen = 0;
    int lastLen = 0;
    cyc_t expq[$];

    multicycle_controller_if bus();

    multicycle_controller #(.STALL_W(STALL_W)) dut (
        .clk(clk),
        .reset(reset),
        .mem(bus),
        .op(op),
        .funct3(funct3),
        .funct7b5(funct7b5),
        .Zero(Zero),
        .IRWrite(IRWrite),
        .PCWrite(PCWrite),
        .RegWrite(RegWrite),
        .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc),
        .ALUControl(ALUControl),
        .InstrDone(InstrDone),
        .StallCount(StallCount)
`ifdef RISCV_ILLEGAL_TRAP_EN
        ,
        .Illegal(Illegal)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] immFor(input logic [6:0] o);
        if (o == 7'b0100011) return 2'b01;
        if (o == 7'b1100011) return 2'b10;
        if (o == 7'b1101111) return 2'b11;
        return 2'b00;
    endfunction

    // Operation named by the instruction: sub only for R-type with funct7b5
    function automatic logic [2:0] aluFor(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (o == 7'b0110011 && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b011;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic cyc_t blank(input logic [6:0] o, input logic z);
        cyc_t c;
        c.rst = 1'b0;  c.partial = 1'b0;  c.ready = 1'b1;  c.zero = z;
        c.memreq = 1'b0;  c.memwrite = 1'b0;  c.adrsrc = 1'b0;  c.irwrite = 1'b0;
        c.pcwrite = 1'b0;  c.regwrite = 1'b0;  c.instrdone = 1'b0;  c.illegal = 1'b0;
        c.resultsrc = 2'b00;  c.srca = 2'b00;  c.srcb = 2'b00;
        c.immsrc = immFor(o);  c.alucontrol = 3'b000;
        return c;
    endfunction

    task automatic stepCycle(input cyc_t c);
        reset = c.rst;
        bus.MemReady = c.ready;
        Zero = c.zero;
        expq.push_back(c);
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c = blank(op, 1'b0);
            c.rst = 1'b1;
            c.partial = 1'b1;
            c.ready = 1'b0;
            stepCycle(c);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                                 input logic z, input int fw, input int mw, input bit abort);
        cyc_t c;
        op = o;
        funct3 = f3;
        funct7b5 = f7;
        for (int i = 0; i <= fw; i++) begin
            c = blank(o, z);
            c.ready = (i == fw);
            c.memreq = 1'b1;
            c.irwrite = c.ready;
            c.pcwrite = c.ready;
            c.resultsrc = 2'b10;
            c.srcb = 2'b10;
            stepCycle(c);
        end
        c = blank(o, z);
        c.srca = 2'b01;
        c.srcb = 2'b01;
        if (!(o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011, 7'b1101111})) begin
`ifdef RISCV_ILLEGAL_TRAP_EN
            stepCycle(c);
            for (int i = 0; i < 4; i++) begin
                c = blank(o, z);
                c.illegal = 1'b1;
                stepCycle(c);
            end
`else
            c.instrdone = 1'b1;
            stepCycle(c);
`endif
            return;
        end
        stepCycle(c);
        if (o == 7'b0000011 || o == 7'b0100011) begin
            c = blank(o, z);
            c.srca = 2'b10;
            c.srcb = 2'b01;
            stepCycle(c);
            for (int i = 0; i <= mw; i++) begin
                c = blank(o, z);
                c.ready = abort ? 1'b0 : (i == mw);
                c.memreq = 1'b1;
                c.adrsrc = 1'b1;
                c.memwrite = (o == 7'b0100011);
                c.instrdone = (o == 7'b0100011) && c.ready;
                stepCycle(c);
                if (abort) return;
            end
            if (o == 7'b0000011) begin
                c = blank(o, z);
                c.resultsrc = 2'b01;
                c.regwrite = 1'b1;
                c.instrdone = 1'b1;
                stepCycle(c);
            end
        end else if (o == 7'b1100011) begin
            c = blank(o, z);
            c.srca = 2'b10;
            c.alucontrol = 3'b001;
            c.instrdone = 1'b1;
            c.pcwrite = (f3 == 3'b000) ? z : (f3 == 3'b001) ? !z : 1'b0;
            stepCycle(c);
        end else begin
            c = blank(o, z);
            if (o == 7'b1101111) begin
                c.srca = 2'b01;
                c.srcb = 2'b10;
                c.pcwrite = 1'b1;
            end else begin
                c.srca = 2'b10;
                c.srcb = (o == 7'b0010011) ? 2'b01 : 2'b00;
                c.alucontrol = aluFor(o, f3, f7);
            end
            stepCycle(c);
            c = blank(o, z);
            c.regwrite = 1'b1;
            c.instrdone = 1'b1;
            stepCycle(c);
        end
    endtask

    task automatic runInstr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input logic z, input int fw, input int mw, input int expLen);
        applyStimulus(o, f3, f7, z, fw, mw, 1'b0);
        checkOutput("instr_len", 32'(lastLen), 32'(expLen));
    endtask

    // Per-cycle comparison against the expected control word
    always @(negedge clk) begin
        cyc_t e;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            checkOutput("MemReq", 32'(bus.MemReq), 32'(e.memreq));
            checkOutput("MemWrite", 32'(bus.MemWrite), 32'(e.memwrite));
            checkOutput("IRWrite", 32'(IRWrite), 32'(e.irwrite));
            checkOutput("PCWrite", 32'(PCWrite), 32'(e.pcwrite));
            checkOutput("RegWrite", 32'(RegWrite), 32'(e.regwrite));
            checkOutput("InstrDone", 32'(InstrDone), 32'(e.instrdone));
            if (!e.partial) begin
                checkOutput("AdrSrc", 32'(bus.AdrSrc), 32'(e.adrsrc));
                checkOutput("ResultSrc", 32'(ResultSrc), 32'(e.resultsrc));
                checkOutput("ALUSrcA", 32'(ALUSrcA), 32'(e.srca));
                checkOutput("ALUSrcB", 32'(ALUSrcB), 32'(e.srcb));
                checkOutput("ImmSrc", 32'(ImmSrc), 32'(e.immsrc));
                checkOutput("ALUControl", 32'(ALUControl), 32'(e.alucontrol));
                checkOutput("StallCount", 32'(StallCount), 32'(modelStall));
`ifdef RISCV_ILLEGAL_TRAP_EN
                checkOutput("Illegal", 32'(Illegal), 32'(e.illegal));
`endif
            end
            if (e.rst) begin
                modelStall = 0;
                runLen = 0;
            end else begin
                if (e.memreq && !e.ready && modelStall < (1 << STALL_W) - 1)
                    modelStall++;
                runLen++;
                if (InstrDone) begin
                    lastLen = runLen;
                    runLen = 0;
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        applyReset(2);
        runInstr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);   // add x3,x1,x2
        runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 2, 7);   // lw, two memory waits
        checkOutput("stall_after_lw", 32'(StallCount), 32'd2);
        runInstr(7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0, 3);   // beq taken
        runInstr(7'b1100011, 3'b001, 1'b0, 1'b1, 0, 0, 3);   // bne not taken
        runInstr(7'b1100011, 3'b001, 1'b0, 1'b0, 0, 0, 3);   // bne taken
        runInstr(7'b1100011, 3'b100, 1'b0, 1'b1, 0, 0, 3);   // unsupported branch funct3
        runInstr(7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0, 4);   // sub
        runInstr(7'b0010011, 3'b000, 1'b1, 1'b0, 0, 0, 4);   // addi with funct7b5 set
        runInstr(7'b0110011, 3'b010, 1'b0, 1'b0, 0, 0, 4);   // slt
        runInstr(7'b0010011, 3'b110, 1'b0, 1'b0, 0, 0, 4);   // ori
        runInstr(7'b0110011, 3'b111, 1'b0, 1'b0, 0, 0, 4);   // and
        runInstr(7'b0010011, 3'b100, 1'b0, 1'b0, 0, 0, 4);   // xori decodes as add
        runInstr(7'b1101111, 3'b000, 1'b0, 1'b0, 0, 0, 4);   // jal
        runInstr(7'b0100011, 3'b010, 1'b0, 1'b0, 1, 1, 6);   // sw, one fetch wait and one write wait
        runInstr(7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0, 5);   // lw, no waits
        checkOutput("stall_accum", 32'(StallCount), 32'd4);
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 0, 0, 1'b1);
        applyReset(1);
        checkOutput("stall_after_reset", 32'(StallCount), 32'd0);
        runInstr(7'b0110011, 3'b000, 1'b0, 1'b0, 0, 0, 4);
`ifdef RISCV_ILLEGAL_TRAP_EN
        applyStimulus(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 1'b0);
        checkOutput("illegal_held", 32'(Illegal), 32'd1);
        applyReset(1);
`else
        runInstr(7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0, 2);
`endif
        applyReset(1);
        runInstr(7'b0110011, 3'b000, 1'b0, 1'b0, 300, 0, 304);
        checkOutput("stall_saturated", 32'(StallCount), 32'd255);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
